memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; all state elements SHALL clear immediately when reset asserts.
REQ-002 The ports SHALL be as follows:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ex_mem_0  input  ex_mem_t  EX/MEM slot 0. Fields used: valid, pc, rd_addr, rd2_addr, rd_we, rd2_we, mem_read, mem_write, mem_size, mem_addr, mem_wdata, alu_result, is_halt.
- ex_mem_1  input  ex_mem_t  EX/MEM slot 1, same fields; slot 1 is younger in program order.
- mem_stall  output  1  hold request to EX and earlier stages; upstream holds ex_mem_0/1 stable while it is high.
- bus_req  output  1  data-bus request.
- bus_we  output  1  1 = store, 0 = load.
- bus_addr  output  32  byte address.
- bus_wdata  output  32  store data, zero-extended.
- bus_size  output  2  access size: 00 = byte, 01 = halfword, 10 = word.
- bus_ack  input  1  transfer complete; may arrive in the same cycle as bus_req.
- bus_rdata  input  32  load data, valid when bus_ack is high.
- mem_wb_0  output  mem_wb_t  MEM/WB slot 0. Fields: valid, pc, rd_addr, rd2_addr, rd_we, rd2_we, wb_data[15:0], wb_data2[15:0], is_halt.
- mem_wb_1  output  mem_wb_t  MEM/WB slot 1, same fields.

Function
REQ-003 A slot SHALL be a memory slot when valid=1 and (mem_read or mem_write)=1; invalid slots SHALL never generate bus activity.
REQ-004 The FSM SHALL have four states: IDLE, ACC0, ACC1 and DONE.
REQ-005 FSM transitions:
- IDLE: if slot 0 is a memory slot, go to ACC0; else if slot 1 is a memory slot, go to ACC1; otherwise stay in IDLE.
- ACC0: on bus_ack, go to ACC1 if slot 1 is a memory slot; otherwise go to DONE.
- ACC1: on bus_ack, go to DONE.
- DONE: go to IDLE unconditionally.
REQ-006 bus_req SHALL be 1 only in ACC0 and ACC1; it SHALL stay asserted, with bus_we, bus_addr, bus_wdata and bus_size stable, until the cycle bus_ack is sampled high.
REQ-007 In ACC0 the bus fields SHALL come from slot 0; in ACC1 they SHALL come from slot 1. bus_addr SHALL equal mem_addr and bus_size SHALL equal mem_size.
REQ-008 bus_wdata SHALL be mem_wdata masked to the access size: [7:0] for a byte access, [15:0] for a halfword access; all other bits SHALL be 0.
REQ-009 With bus_req=0, bus_we, bus_addr, bus_wdata and bus_size SHALL all be 0.
REQ-010 Slots SHALL be serviced strictly slot 0 then slot 1, so a slot-1 load from a slot-0 store address returns the stored data.
REQ-011 Load data SHALL be captured at the bus_ack edge into a per-slot load register:
- byte load: wb_data = {8'h0, rdata[7:0]}.
- halfword load: wb_data = rdata[15:0].
- word load: wb_data = rdata[15:0] and wb_data2 = rdata[31:16].
REQ-012 Writeback data for non-load slots, including stores: wb_data = alu_result[15:0] and wb_data2 = alu_result[31:16].
REQ-013 mem_stall SHALL be 1 in ACC0 and ACC1, and in IDLE whenever either slot is a memory slot; it SHALL be 0 otherwise, including in DONE.
REQ-014 mem_wb_0/1 SHALL be registered. At each rising edge with mem_stall=0, they SHALL load the current slot fields plus the selected writeback data.
REQ-015 At each rising edge with mem_stall=1, mem_wb_0.valid and mem_wb_1.valid SHALL be cleared (bubble); all other mem_wb fields SHALL be don't-care.
REQ-016 Latency:
- Non-memory pair: mem_wb is valid 1 cycle after presentation.
- One access with zero-wait ack: IDLE, ACC0, DONE; mem_wb is valid at the third edge.
- Each wait cycle SHALL add one cycle.
REQ-017 is_halt, pc, rd_addr, rd2_addr, rd_we and rd2_we SHALL pass through unchanged for both slots.
REQ-018 A store slot SHALL write back rd_we and rd2_we exactly as presented; the stage SHALL NOT modify them.

Reset
REQ-019 On reset assertion, the FSM SHALL go to IDLE, the load registers SHALL clear, every mem_wb field SHALL be 0, and bus_req SHALL be 0; these SHALL hold in the same cycle, independent of clk.
REQ-020 Reset asserted during ACC0 or ACC1 SHALL abandon the transfer with no capture; the first cycle after release SHALL be IDLE.
REQ-021 mem_stall after reset SHALL follow REQ-013 from IDLE.

Verification
REQ-022 Scenario, non-memory pass-through:
- Stimulus: slot 0 valid ADD, alu_result=32'h0000_1234, rd_addr=3; slot 1 invalid.
- Required response: mem_stall=0, no bus_req; next cycle mem_wb_0.valid=1, wb_data=16'h1234, mem_wb_1.valid=0.
REQ-023 Scenario, zero-wait halfword load:
- Stimulus: slot 0 halfword load, addr 32'h0000_0100; bus_ack in the first ACC0 cycle with bus_rdata=32'hDEAD_BEEF.
- Required response: bus_req for exactly 1 cycle; mem_wb_0.wb_data=16'hBEEF at the third edge; mem_stall high for 2 cycles.
REQ-024 Scenario, dual store then byte load to the same address:
- Stimulus: slot 0 stores 16'hA5C3 to 32'h200 as a byte; slot 1 loads a byte from 32'h200; bus model returns the written byte.
- Required response: store (bus_wdata=32'h0000_00C3) precedes load; mem_wb_1.wb_data=16'h00C3; both mem_wb valid in the same cycle.
REQ-025 Scenario, wait states:
- Stimulus: slot 1 word load with bus_ack delayed 3 cycles, bus_rdata=32'h1111_2222.
- Required response: bus_addr stable for 4 cycles; wb_data=16'h2222 and wb_data2=16'h1111; exactly one bubble edge per stalled cycle.
REQ-026 Scenario, reset mid-transfer:
- Stimulus: rst asserted in the second ACC0 wait cycle.
- Required response: bus_req and mem_wb valid go to 0 in the same cycle; after release, IDLE with no spurious writeback.
REQ-027 Scenario, halt pass-through:
- Stimulus: slot 0 is_halt=1, no memory access.
- Required response: next cycle mem_wb_0.is_halt=1 and valid=1.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage for a dual-issue pipeline: serialises up to two data-bus accesses
// (slot 0 first, then slot 1) and registers both slots into MEM/WB.
package memory_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [4:0]  rd2_addr;
        logic        rd_we;
        logic        rd2_we;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] alu_result;
        logic        is_halt;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [4:0]  rd2_addr;
        logic        rd_we;
        logic        rd2_we;
        logic [15:0] wb_data;
        logic [15:0] wb_data2;
        logic        is_halt;
    } mem_wb_t;

endpackage

module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_t     ex_mem_0,
    input  ex_mem_t     ex_mem_1,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output mem_wb_t     mem_wb_0,
    output mem_wb_t     mem_wb_1
);

    // Bus handshake: bus_req and all bus fields stay put from the first request
    // cycle until the edge on which bus_ack is sampled high; the transfer
    // completes on that edge and bus_ack is ignored whenever bus_req is low.
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state;
    logic        mem_slot_0;
    logic        mem_slot_1;
    logic        is_load_0;
    logic        is_load_1;
    logic [31:0] ld_data_0;
    logic [31:0] ld_data_1;
    mem_wb_t     wb_next_0;
    mem_wb_t     wb_next_1;

    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   size_mask = {24'h0, d[7:0]};
            2'b01:   size_mask = {16'h0, d[15:0]};
            default: size_mask = d;
        endcase
    endfunction

    // Load registers hold {wb_data2, wb_data} already formatted for writeback.
    function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic [31:0] r);
        case (size)
            2'b00:   fmt_load = {16'h0, 8'h0, r[7:0]};
            2'b01:   fmt_load = {16'h0, r[15:0]};
            default: fmt_load = r;
        endcase
    endfunction

    assign mem_slot_0 = ex_mem_0.valid & (ex_mem_0.mem_read | ex_mem_0.mem_write);
    assign mem_slot_1 = ex_mem_1.valid & (ex_mem_1.mem_read | ex_mem_1.mem_write);
    assign is_load_0  = ex_mem_0.valid & ex_mem_0.mem_read & ~ex_mem_0.mem_write;
    assign is_load_1  = ex_mem_1.valid & ex_mem_1.mem_read & ~ex_mem_1.mem_write;

    assign mem_stall = (state == ACC0) | (state == ACC1)
                     | ((state == IDLE) & (mem_slot_0 | mem_slot_1));

    always_comb begin
        bus_req   = (state == ACC0) | (state == ACC1);
        bus_we    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_size  = 2'b00;
        if (state == ACC0) begin
            bus_we    = ex_mem_0.mem_write;
            bus_addr  = ex_mem_0.mem_addr;
            bus_wdata = size_mask(ex_mem_0.mem_size, ex_mem_0.mem_wdata);
            bus_size  = ex_mem_0.mem_size;
        end else if (state == ACC1) begin
            bus_we    = ex_mem_1.mem_write;
            bus_addr  = ex_mem_1.mem_addr;
            bus_wdata = size_mask(ex_mem_1.mem_size, ex_mem_1.mem_wdata);
            bus_size  = ex_mem_1.mem_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ld_data_0 <= 32'h0;
            ld_data_1 <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_slot_0)      state <= ACC0;
                    else if (mem_slot_1) state <= ACC1;
                end
                ACC0: begin
                    if (bus_ack) begin
                        ld_data_0 <= fmt_load(ex_mem_0.mem_size, bus_rdata);
                        state     <= mem_slot_1 ? ACC1 : DONE;
                    end
                end
                ACC1: begin
                    if (bus_ack) begin
                        ld_data_1 <= fmt_load(ex_mem_1.mem_size, bus_rdata);
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_next_0          = '0;
        wb_next_0.valid    = ex_mem_0.valid;
        wb_next_0.pc       = ex_mem_0.pc;
        wb_next_0.rd_addr  = ex_mem_0.rd_addr;
        wb_next_0.rd2_addr = ex_mem_0.rd2_addr;
        wb_next_0.rd_we    = ex_mem_0.rd_we;
        wb_next_0.rd2_we   = ex_mem_0.rd2_we;
        wb_next_0.is_halt  = ex_mem_0.is_halt;
        {wb_next_0.wb_data2, wb_next_0.wb_data} = is_load_0 ? ld_data_0 : ex_mem_0.alu_result;

        wb_next_1          = '0;
        wb_next_1.valid    = ex_mem_1.valid;
        wb_next_1.pc       = ex_mem_1.pc;
        wb_next_1.rd_addr  = ex_mem_1.rd_addr;
        wb_next_1.rd2_addr = ex_mem_1.rd2_addr;
        wb_next_1.rd_we    = ex_mem_1.rd_we;
        wb_next_1.rd2_we   = ex_mem_1.rd2_we;
        wb_next_1.is_halt  = ex_mem_1.is_halt;
        {wb_next_1.wb_data2, wb_next_1.wb_data} = is_load_1 ? ld_data_1 : ex_mem_1.alu_result;
    end

    // While stalled only the valid bits are cleared; the rest is don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_0 <= '0;
            mem_wb_1 <= '0;
        end else if (mem_stall) begin
            mem_wb_0.valid <= 1'b0;
            mem_wb_1.valid <= 1'b0;
        end else begin
            mem_wb_0 <= wb_next_0;
            mem_wb_1 <= wb_next_1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random slot pairs, checked against
// a byte-addressed reference memory and a cycle-count model of the access sequence.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int W = $bits(mem_wb_t);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    ex_mem_t     ex_mem_0, ex_mem_1;
    logic        mem_stall, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  bus_size;
    mem_wb_t     mem_wb_0, mem_wb_1;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .ex_mem_0(ex_mem_0), .ex_mem_1(ex_mem_1),
        .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_size(bus_size),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_wb_0(mem_wb_0), .mem_wb_1(mem_wb_1)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] care_q[$];
    logic [7:0]   bus_mem[4096];
    logic [7:0]   ref_mem[4096];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [31:0] sized(input logic [1:0] size, input logic [31:0] d);
        logic [63:0] m;
        m = (64'd1 << (8 << size)) - 64'd1;
        return d & m[31:0];
    endfunction

    function automatic logic [31:0] ref_apply(input ex_mem_t s);
        logic [31:0] v;
        int idx;
        v = 32'h0;
        for (int i = 0; i < (1 << s.mem_size); i++) begin
            idx = int'((s.mem_addr + 32'(i)) & 32'hFFF);
            if (s.mem_write) ref_mem[idx] = s.mem_wdata[8*i +: 8];
            else             v[8*i +: 8] = ref_mem[idx];
        end
        return v;
    endfunction

    function automatic mem_wb_t ref_wb(input ex_mem_t s, input logic [31:0] ld);
        mem_wb_t e;
        e          = '0;
        e.valid    = s.valid;
        e.pc       = s.pc;
        e.rd_addr  = s.rd_addr;
        e.rd2_addr = s.rd2_addr;
        e.rd_we    = s.rd_we;
        e.rd2_we   = s.rd2_we;
        e.is_halt  = s.is_halt;
        if (s.valid && s.mem_read && !s.mem_write) {e.wb_data2, e.wb_data} = ld;
        else                                       {e.wb_data2, e.wb_data} = s.alu_result;
        return e;
    endfunction

    function automatic mem_wb_t ref_care(input ex_mem_t s);
        mem_wb_t c;
        c = '1;
        if (!s.valid) begin
            c       = '0;
            c.valid = 1'b1;
        end else if (s.mem_read && !s.mem_write && s.mem_size != 2'b10) begin
            c.wb_data2 = '0;
        end
        return c;
    endfunction

    function automatic ex_mem_t rand_slot();
        ex_mem_t s;
        s            = '0;
        s.valid      = ($urandom_range(0, 3) != 0);
        s.pc         = $urandom;
        s.rd_addr    = 5'($urandom_range(0, 31));
        s.rd2_addr   = 5'($urandom_range(0, 31));
        s.rd_we      = 1'($urandom_range(0, 1));
        s.rd2_we     = 1'($urandom_range(0, 1));
        s.is_halt    = ($urandom_range(0, 15) == 0);
        s.alu_result = $urandom;
        case ($urandom_range(0, 2))
            1:       s.mem_read  = 1'b1;
            2:       s.mem_write = 1'b1;
            default: ;
        endcase
        s.mem_size  = 2'($urandom_range(0, 2));
        s.mem_addr  = 32'h200 + 32'($urandom_range(0, 7));
        s.mem_wdata = $urandom;
        return s;
    endfunction

    // scoreboard
    task automatic check_wb(input string tag);
        logic [W-1:0] e0, e1, c0, c1, o0, o1;
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
        c0 = care_q.pop_front(); c1 = care_q.pop_front();
        o0 = mem_wb_0; o1 = mem_wb_1;
        check_eq({tag, "_wb0"}, 128'(o0 & c0), 128'(e0 & c0));
        check_eq({tag, "_wb1"}, 128'(o1 & c1), 128'(e1 & c1));
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_bubble"}, 128'({mem_wb_0.valid, mem_wb_1.valid}), 128'(2'b00));
    endtask

    task automatic check_quiet(input string tag, input logic exp_stall);
        check_eq({tag, "_stall"}, 128'(mem_stall), 128'(exp_stall));
        check_eq({tag, "_quiet"}, 128'({bus_req, bus_we, bus_addr, bus_wdata, bus_size}), 128'(0));
    endtask

    // driver: presents a pair at a negedge and walks the expected cycle sequence
    task automatic run_pair(input string tag, input ex_mem_t s0, input ex_mem_t s1,
                            input int w0, input int w1);
        ex_mem_t     acc_s[2];
        int          acc_w[2];
        int          n;
        logic [31:0] v0, v1;
        int          idx;
        n  = 0;
        v0 = 32'h0;
        v1 = 32'h0;
        if (s0.valid && (s0.mem_read || s0.mem_write)) begin
            acc_s[n] = s0; acc_w[n] = w0; n++;
            v0 = ref_apply(s0);
        end
        if (s1.valid && (s1.mem_read || s1.mem_write)) begin
            acc_s[n] = s1; acc_w[n] = w1; n++;
            v1 = ref_apply(s1);
        end
        exp_q.push_back(ref_wb(s0, v0));
        exp_q.push_back(ref_wb(s1, v1));
        care_q.push_back(ref_care(s0));
        care_q.push_back(ref_care(s1));

        ex_mem_0 = s0;
        ex_mem_1 = s1;
        #1;
        if (n == 0) begin
            check_quiet({tag, "_pass"}, 1'b0);
            @(negedge clk);
            check_wb(tag);
            return;
        end
        check_quiet({tag, "_idle"}, 1'b1);
        @(negedge clk);
        check_bubble({tag, "_idle"});
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w <= acc_w[k]; w++) begin
                #1;
                check_eq({tag, "_req"}, 128'({bus_req, mem_stall}), 128'(2'b11));
                check_eq({tag, "_bus"}, 128'({bus_we, bus_size, bus_addr, bus_wdata}),
                         128'({acc_s[k].mem_write, acc_s[k].mem_size, acc_s[k].mem_addr,
                               sized(acc_s[k].mem_size, acc_s[k].mem_wdata)}));
                bus_rdata = $urandom;
                bus_ack   = 1'b0;
                if (w == acc_w[k]) begin
                    bus_ack = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        idx = int'((bus_addr + 32'(i)) & 32'hFFF);
                        if (bus_we && i < (1 << bus_size)) bus_mem[idx] = bus_wdata[8*i +: 8];
                        else if (!bus_we)                   bus_rdata[8*i +: 8] = bus_mem[idx];
                    end
                end
                @(negedge clk);
                bus_ack = 1'b0;
                check_bubble({tag, "_acc"});
            end
        end
        #1;
        check_quiet({tag, "_done"}, 1'b0);
        @(negedge clk);
        check_wb(tag);
    endtask

    task automatic reset_mid_transfer();
        ex_mem_t s0, s1;
        s0 = '0; s1 = '0;
        s0.valid = 1'b1; s0.mem_read = 1'b1; s0.mem_size = 2'b01; s0.mem_addr = 32'h104;
        ex_mem_0 = s0; ex_mem_1 = s1;
        #1 check_eq("rmt_idle", 128'({mem_stall, bus_req}), 128'(2'b10));
        @(negedge clk);
        #1 check_eq("rmt_wait1", 128'(bus_req), 128'(1));
        @(negedge clk);
        #1 check_eq("rmt_wait2", 128'(bus_req), 128'(1));
        rst = 1'b1;
        #1;
        check_eq("rmt_req", 128'(bus_req), 128'(0));
        check_eq("rmt_wb", 128'({mem_wb_0, mem_wb_1}), 128'(0));
        check_eq("rmt_stall", 128'(mem_stall), 128'(1));
        @(negedge clk);
        ex_mem_0 = '0;
        rst = 1'b0;
        #1 check_quiet("rmt_release", 1'b0);
        @(negedge clk);
        check_eq("rmt_no_wb", 128'({mem_wb_0.valid, mem_wb_1.valid}), 128'(2'b00));
    endtask

    initial begin
        ex_mem_t s0, s1, inv;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        ex_mem_0  = '0;
        ex_mem_1  = '0;
        inv       = '0;
        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        #2 rst = 1'b1;
        #1;
        check_quiet("reset", 1'b0);
        check_eq("reset_wb", 128'({mem_wb_0, mem_wb_1}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // non-memory pass-through
        s0 = '0; s0.valid = 1'b1; s0.alu_result = 32'h0000_1234; s0.rd_addr = 5'd3; s0.rd_we = 1'b1;
        run_pair("add", s0, inv, 0, 0);
        check_eq("add_data", 128'({mem_wb_0.valid, mem_wb_0.wb_data, mem_wb_1.valid}),
                 128'({1'b1, 16'h1234, 1'b0}));

        // zero-wait halfword load
        {bus_mem[12'h103], bus_mem[12'h102], bus_mem[12'h101], bus_mem[12'h100]} = 32'hDEAD_BEEF;
        {ref_mem[12'h103], ref_mem[12'h102], ref_mem[12'h101], ref_mem[12'h100]} = 32'hDEAD_BEEF;
        s0 = '0; s0.valid = 1'b1; s0.mem_read = 1'b1; s0.mem_size = 2'b01; s0.mem_addr = 32'h100;
        run_pair("lh", s0, inv, 0, 0);
        check_eq("lh_data", 128'(mem_wb_0.wb_data), 128'(16'hBEEF));

        // byte store then byte load of the same address
        s0 = '0; s0.valid = 1'b1; s0.mem_write = 1'b1; s0.mem_size = 2'b00;
        s0.mem_addr = 32'h200; s0.mem_wdata = 32'h0000_A5C3; s0.rd_we = 1'b1; s0.rd2_we = 1'b1;
        s1 = '0; s1.valid = 1'b1; s1.mem_read = 1'b1; s1.mem_size = 2'b00; s1.mem_addr = 32'h200;
        run_pair("st_ld", s0, s1, 1, 0);
        check_eq("st_ld_data", 128'({mem_wb_0.valid, mem_wb_1.valid, mem_wb_1.wb_data}),
                 128'({1'b1, 1'b1, 16'h00C3}));

        // slot-1 word load with three wait cycles
        {bus_mem[12'h303], bus_mem[12'h302], bus_mem[12'h301], bus_mem[12'h300]} = 32'h1111_2222;
        {ref_mem[12'h303], ref_mem[12'h302], ref_mem[12'h301], ref_mem[12'h300]} = 32'h1111_2222;
        s1 = '0; s1.valid = 1'b1; s1.mem_read = 1'b1; s1.mem_size = 2'b10; s1.mem_addr = 32'h300;
        run_pair("lw_wait", inv, s1, 0, 3);
        check_eq("lw_wait_data", 128'({mem_wb_1.wb_data2, mem_wb_1.wb_data}), 128'(32'h1111_2222));

        reset_mid_transfer();

        // halt pass-through
        s0 = '0; s0.valid = 1'b1; s0.is_halt = 1'b1;
        run_pair("halt", s0, inv, 0, 0);
        check_eq("halt_out", 128'({mem_wb_0.valid, mem_wb_0.is_halt}), 128'(2'b11));

        for (int t = 0; t < 80; t++) begin
            s0 = rand_slot();
            s1 = rand_slot();
            run_pair("rand", s0, s1, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        check_eq("sb_drain", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
